// File: rtl/ads_i2c_target.sv
`timescale 1ns/1ps
// ads_i2c_target
// I2C target that emulates an ADS1115-style register map (conversion at
// pointer 0, config at pointer 1) at a fixed 7-bit address. It is used as the
// bus-side stand-in for a hardware-in-loop converter model. SCL and SDA are
// oversampled on clk_i. SDA is only ever pulled low: 1 on sda_pull_o means low.
module ads_i2c_target #(
  parameter logic [6:0]  ADDRESS     = 7'b1001001,
  parameter logic [15:0] CFG_RESET   = 16'h8583,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_pull_o,
  input  logic [15:0] sample_i,
  input  logic        sample_valid_i,
  output logic [15:0] config_o,
  output logic        config_wr_o,
  output logic        conv_start_o,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_MSB, MSB_ACK, WR_LSB, LSB_ACK,
    WR_IGN, IGN_ACK, RD_MSB, RD_ACK1, RD_LSB, RD_ACK2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_q, sda_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_c, stop_c;
  logic [7:0]             shreg_q, wr_msb_q;
  logic [2:0]             bit_cnt_q;
  logic                   byte_rdy_q, rw_q, m_nack_q, ptr_q;
  logic [15:0]            rd_buf_q, conv_q;
  logic                   in_byte, in_rd_ack;
  logic                   pull_d, addr_ok, ptr_we, msb_we, cfg_we;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_c   = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_c    = scl_s & scl_q & ~sda_q & sda_s;
  assign in_byte   = state_q inside {ADDR, PTR, WR_MSB, WR_LSB, WR_IGN, RD_MSB, RD_LSB};
  assign in_rd_ack = state_q inside {RD_ACK1, RD_ACK2};

  // Synchronize the bus lines and keep one previous sample for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // The bus idles high; resetting to 1 keeps reset release from faking an edge.
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // so the chain shifts by exactly one stage per clock.
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_q      <= scl_s;
      sda_q      <= sda_s;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, next SDA drive and update strobes; byte decisions happen on SCL fall.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    pull_d  = sda_pull_o;
    addr_ok = 1'b0;
    ptr_we  = 1'b0;
    msb_we  = 1'b0;
    cfg_we  = 1'b0;
    if (start_c) begin
      state_d = ADDR;
      pull_d  = 1'b0;
    end else if (stop_c) begin
      state_d = IDLE;
      pull_d  = 1'b0;
    end else if (scl_fall) begin
      case (state_q)
        IDLE: ;
        ADDR: if (byte_rdy_q) begin
          if (shreg_q[7:1] == ADDRESS) begin
            state_d = ADDR_ACK;
            pull_d  = 1'b1;
            addr_ok = 1'b1;
          end else begin
            state_d = IDLE;
            pull_d  = 1'b0;
          end
        end
        ADDR_ACK: begin
          state_d = rw_q ? RD_MSB : PTR;
          pull_d  = rw_q & ~rd_buf_q[15];
        end
        PTR: if (byte_rdy_q) begin
          if (shreg_q[7:1] == 7'd0) begin
            state_d = PTR_ACK;
            pull_d  = 1'b1;
            ptr_we  = 1'b1;
          end else begin
            state_d = IDLE;
            pull_d  = 1'b0;
          end
        end
        PTR_ACK: begin state_d = WR_MSB; pull_d = 1'b0; end
        WR_MSB: if (byte_rdy_q) begin
          state_d = MSB_ACK;
          pull_d  = 1'b1;
          msb_we  = 1'b1;
        end
        MSB_ACK: begin state_d = WR_LSB; pull_d = 1'b0; end
        WR_LSB:  if (byte_rdy_q) begin state_d = LSB_ACK; pull_d = 1'b1; end
        LSB_ACK: begin
          state_d = WR_IGN;
          pull_d  = 1'b0;
          cfg_we  = ptr_q;
        end
        WR_IGN:  if (byte_rdy_q) begin state_d = IGN_ACK; pull_d = 1'b1; end
        IGN_ACK: begin state_d = WR_IGN; pull_d = 1'b0; end
        RD_MSB: begin
          if (byte_rdy_q) begin state_d = RD_ACK1; pull_d = 1'b0; end
          else pull_d = ~rd_buf_q[{1'b1, ~bit_cnt_q}];
        end
        RD_ACK1: begin
          state_d = m_nack_q ? IDLE : RD_LSB;
          pull_d  = ~m_nack_q & ~rd_buf_q[7];
        end
        RD_LSB: begin
          if (byte_rdy_q) begin state_d = RD_ACK2; pull_d = 1'b0; end
          else pull_d = ~rd_buf_q[{1'b0, ~bit_cnt_q}];
        end
        RD_ACK2: begin
          state_d = m_nack_q ? IDLE : RD_MSB;
          pull_d  = ~m_nack_q & ~rd_buf_q[15];
        end
        default: begin state_d = IDLE; pull_d = 1'b0; end
      endcase
    end
  end

  // Shift in bus bits on SCL rise and flag the eighth bit of each byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      byte_rdy_q <= 1'b0;
      m_nack_q   <= 1'b0;
    end else begin
      if (start_c || stop_c) begin
        bit_cnt_q  <= '0;
        byte_rdy_q <= 1'b0;
      end else if (scl_rise && in_byte) begin
        shreg_q    <= {shreg_q[6:0], sda_s};
        bit_cnt_q  <= bit_cnt_q + 3'd1;
        byte_rdy_q <= (bit_cnt_q == 3'd7);
      end else if (scl_fall) begin
        byte_rdy_q <= 1'b0;
      end
      if (scl_rise && in_rd_ack) m_nack_q <= sda_s;
    end
  end

  // Transaction context: SDA drive, busy, direction, pointer and read snapshot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sda_pull_o <= 1'b0;
      busy_o     <= 1'b0;
      rw_q       <= 1'b0;
      ptr_q      <= 1'b0;
      wr_msb_q   <= '0;
      rd_buf_q   <= '0;
    end else begin
      sda_pull_o <= pull_d;
      if (stop_c) busy_o <= 1'b0;
      if (addr_ok) begin
        busy_o <= 1'b1;
        rw_q   <= shreg_q[0];
        if (shreg_q[0]) rd_buf_q <= ptr_q ? config_o : conv_q;
      end
      if (ptr_we) ptr_q    <= shreg_q[0];
      if (msb_we) wr_msb_q <= shreg_q;
    end
  end

  // Register file: conversion result, config with the OS bit, and write strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      config_o     <= CFG_RESET;
      conv_q       <= '0;
      config_wr_o  <= 1'b0;
      conv_start_o <= 1'b0;
    end else begin
      config_wr_o  <= cfg_we;
      conv_start_o <= cfg_we & wr_msb_q[7];
      if (sample_valid_i) conv_q <= sample_i;
      // A config write clears OS even when a sample lands in the same cycle.
      if (cfg_we)              config_o     <= {1'b0, wr_msb_q[6:0], shreg_q};
      else if (sample_valid_i) config_o[15] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ads_i2c_target.sv
`timescale 1ns/1ps
// tb_ads_i2c_target
// Bus-level I2C master driving the target, with a register-map reference model
// (config, conversion, pointer, pulse counts) and randomized transactions.
module tb_ads_i2c_target;

  localparam int Q = 6;  // clk_i cycles per SCL half-phase segment

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic        sda_pull_o;
  logic [15:0] config_o;
  logic        config_wr_o, conv_start_o, busy_o;
  logic        sda_bus;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_pulses = 0;
  int st_pulses = 0;

  // Reference model state.
  logic [15:0] cfg_m  = 16'h8583;
  logic [15:0] conv_m = 16'h0000;
  logic        ptr_m  = 1'b0;
  int          exp_wr = 0;
  int          exp_st = 0;

  assign sda_bus = sda_m & ~sda_pull_o;

  always #5 clk_i = ~clk_i;

  ads_i2c_target dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .scl_i          (scl),
    .sda_i          (sda_bus),
    .sda_pull_o     (sda_pull_o),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .config_o       (config_o),
    .config_wr_o    (config_wr_o),
    .conv_start_o   (conv_start_o),
    .busy_o         (busy_o)
  );

  // Count strobe pulses.
  always @(posedge clk_i) begin
    if (config_wr_o)  wr_pulses <= wr_pulses + 1;
    if (conv_start_o) st_pulses <= st_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      wait_clk(2); sda_m = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    end else begin
      sda_m = 1'b1; wait_clk(Q);
    end
    sda_m = 1'b0; wait_clk(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(2); sda_m = 1'b0; wait_clk(Q); scl = 1'b1; wait_clk(Q); sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(2); sda_m = b; wait_clk(Q); scl = 1'b1; wait_clk(Q); scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_clk(2); sda_m = 1'b1; wait_clk(Q); scl = 1'b1;
    wait_clk(Q/2); b = sda_bus; wait_clk(Q - Q/2); scl = 1'b0;
  endtask

  task automatic do_strobe(input logic [15:0] v);
    sample_i = v; sample_valid_i = 1'b1;
    wait_clk(1);
    sample_valid_i = 1'b0;
    conv_m = v; cfg_m[15] = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_n);
  endtask

  task automatic recv_byte(input logic nack, input logic strobe_en, input logic [15:0] sv,
                           output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
      if (strobe_en && i == 4) do_strobe(sv);
    end
    send_bit(nack);
  endtask

  // Write frame: pointer byte then nbytes data bytes (MSB, LSB, then extras).
  task automatic do_write(input logic [7:0] ptr, input logic [15:0] data, input int nbytes,
                          input string tag);
    logic a;
    bus_start();
    send_byte(8'h92, a);
    check({tag, "_addr_ack"}, 32'(a), 0);
    check({tag, "_busy"}, 32'(busy_o), 1);
    send_byte(ptr, a);
    check({tag, "_ptr_ack"}, 32'(a), (ptr < 8'd2) ? 0 : 1);
    if (ptr < 8'd2) begin
      ptr_m = ptr[0];
      for (int i = 0; i < nbytes; i++) begin
        send_byte((i == 0) ? data[15:8] : (i == 1) ? data[7:0] : 8'($urandom()), a);
        check($sformatf("%s_data%0d_ack", tag, i), 32'(a), 0);
      end
      if (ptr_m && nbytes >= 2) begin
        cfg_m = {1'b0, data[14:0]};
        exp_wr++;
        if (data[15]) exp_st++;
      end
    end else begin
      wait_clk(Q);
      check({tag, "_nack_state"}, 32'(dut.state_q == dut.IDLE), 1);
    end
    bus_stop();
    check({tag, "_config"}, 32'(config_o), 32'(cfg_m));
    check({tag, "_busy_end"}, 32'(busy_o), 0);
    check({tag, "_wr_pulses"}, wr_pulses, exp_wr);
    check({tag, "_st_pulses"}, st_pulses, exp_st);
  endtask

  // Read frame, optionally setting the pointer first via a repeated START.
  task automatic do_read(input int set_ptr, input int nbytes, input logic strobe_en,
                         input logic [15:0] sv, input string tag);
    logic a;
    logic [7:0] d;
    logic [15:0] snap;
    bus_start();
    if (set_ptr >= 0) begin
      send_byte(8'h92, a);
      check({tag, "_waddr_ack"}, 32'(a), 0);
      send_byte(set_ptr[7:0], a);
      check({tag, "_ptr_ack"}, 32'(a), 0);
      ptr_m = set_ptr[0];
      bus_start();
    end
    send_byte(8'h93, a);
    check({tag, "_raddr_ack"}, 32'(a), 0);
    snap = ptr_m ? cfg_m : conv_m;
    for (int i = 0; i < nbytes; i++) begin
      recv_byte(i == nbytes - 1, strobe_en && i == 1, sv, d);
      check($sformatf("%s_byte%0d", tag, i), 32'(d), 32'((i % 2 == 0) ? snap[15:8] : snap[7:0]));
    end
    wait_clk(Q);
    check({tag, "_released"}, 32'(sda_pull_o), 0);
    bus_stop();
    check({tag, "_busy_end"}, 32'(busy_o), 0);
  endtask

  task automatic do_bad_addr(input logic [6:0] addr, input logic rw, input string tag);
    logic a;
    bus_start();
    send_byte({addr, rw}, a);
    check({tag, "_nack"}, 32'(a), 1);
    check({tag, "_pull"}, 32'(sda_pull_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    bus_stop();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic a;
    logic [6:0] ba;
    int op;

    wait_clk(4);
    check("rst_pull", 32'(sda_pull_o), 0);
    check("rst_config", 32'(config_o), 32'h8583);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_cfg_wr", 32'(config_wr_o), 0);
    check("rst_conv_start", 32'(conv_start_o), 0);
    rst_ni = 1'b1;
    wait_clk(4);

    do_write(8'h01, 16'h8483, 2, "cfg_write");
    check("cfg_write_value", 32'(config_o), 32'h0483);

    do_strobe(16'h733A);
    do_read(0, 2, 1'b0, 16'h0, "conv_read");

    do_bad_addr(7'h48, 1'b0, "bad_addr");
    do_read(-1, 2, 1'b0, 16'h0, "after_bad_addr");

    do_strobe(16'h2653);
    do_read(0, 2, 1'b1, 16'h4CCE, "coherent");
    do_read(-1, 2, 1'b0, 16'h0, "coherent_next");

    do_write(8'h02, 16'h0, 0, "bad_ptr");

    do_read(1, 4, 1'b0, 16'h0, "cfg_read_wrap");

    for (int it = 0; it < 30; it++) begin
      op = int'($urandom_range(0, 5));
      case (op)
        0: do_strobe(16'($urandom()));
        1: do_write(8'h01, 16'($urandom()), int'($urandom_range(0, 3)), $sformatf("r%0d_cfg", it));
        2: do_write(8'h00, 16'($urandom()), 2, $sformatf("r%0d_convwr", it));
        3: do_read(int'($urandom_range(0, 2)) - 1, int'($urandom_range(1, 4)), 1'b0, 16'h0,
                   $sformatf("r%0d_rd", it));
        4: begin
          ba = 7'($urandom());
          if (ba == 7'h49) ba = 7'h48;
          do_bad_addr(ba, 1'($urandom()), $sformatf("r%0d_badaddr", it));
        end
        default: do_write(8'($urandom_range(2, 255)), 16'h0, 0, $sformatf("r%0d_badptr", it));
      endcase
    end

    // Reset while the target drives a 0 data bit.
    do_strobe(16'h2653);
    bus_start();
    send_byte(8'h92, a);
    send_byte(8'h00, a);
    bus_start();
    send_byte(8'h93, a);
    wait_clk(Q);
    check("rst_mid_pre_pull", 32'(sda_pull_o), 1);
    scl = 1'b1;
    wait_clk(2);
    #2 rst_ni = 1'b0;
    #1 check("rst_mid_async_pull", 32'(sda_pull_o), 0);
    check("rst_mid_config", 32'(config_o), 32'h8583);
    check("rst_mid_busy", 32'(busy_o), 0);
    check("rst_mid_cfg_wr", 32'(config_wr_o), 0);
    check("rst_mid_conv_start", 32'(conv_start_o), 0);
    sda_m = 1'b1;
    wait_clk(4);
    rst_ni = 1'b1;
    cfg_m = 16'h8583; conv_m = 16'h0000; ptr_m = 1'b0;
    wait_clk(4);
    do_read(-1, 2, 1'b0, 16'h0, "post_rst_conv");
    do_read(1, 2, 1'b0, 16'h0, "post_rst_cfg");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
